// File: rtl/xfer_pkg.sv
// Shared types and constants for the row transfer controller.
// Mode encodings match the address_calc select inputs.
package xfer_pkg;

  localparam int ADDR_W = 26;
  localparam int DIM_W  = 13;
  localparam int DATA_W = 16;

  localparam logic SRAM_ROWCACHE = 1'b1;
  localparam logic SRAM_OUTPUT   = 1'b0;
  localparam logic SDRAM_READ    = 1'b1;
  localparam logic SDRAM_WRITE   = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    LD_RD,
    LD_WR,
    LD_UPD,
    PROC,
    ST_RD,
    ST_WR,
    ST_UPD,
    ROW_END,
    DONE
  } xfer_state_t;

endpackage

// File: rtl/word_mover.sv
// One-word read-then-write handshake engine: go_i launches a source read,
// the captured word is then written to the destination until it acks.
module word_mover #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go_i,
  input  logic         src_ack_i,
  input  logic [W-1:0] src_rdata_i,
  input  logic         dst_ack_i,
  output logic         src_req_o,
  output logic         dst_req_o,
  output logic [W-1:0] data_o,
  output logic         src_fire_o,
  output logic         done_o
);

  logic         src_req_q, src_req_d;
  logic         dst_req_q, dst_req_d;
  logic [W-1:0] data_q, data_d;

  // Acks only count while the matching request is up; stray acks fall away here.
  assign src_fire_o = src_req_q & src_ack_i;
  assign done_o     = dst_req_q & dst_ack_i;

  always_comb begin
    src_req_d = src_req_q;
    dst_req_d = dst_req_q;
    data_d    = data_q;
    if (go_i) begin
      src_req_d = 1'b1;
    end
    if (src_fire_o) begin
      src_req_d = 1'b0;
      dst_req_d = 1'b1;
      data_d    = src_rdata_i;
    end
    if (done_o) begin
      dst_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_req_q <= 1'b0;
      dst_req_q <= 1'b0;
      data_q    <= '0;
    end else begin
      src_req_q <= src_req_d;
      dst_req_q <= dst_req_d;
      data_q    <= data_d;
    end
  end

  assign src_req_o = src_req_q;
  assign dst_req_o = dst_req_q;
  assign data_o    = data_q;

endmodule

// File: rtl/row_transfer_ctrl.sv
// Row sequencer: loads each image row SDRAM->SRAM, hands it to the filter,
// then stores width-1 results SRAM->SDRAM while steering address_calc.
module row_transfer_ctrl
  import xfer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  image_width,
  input  logic [DIM_W-1:0]  image_height,
  output logic              calc_start,
  output logic              update,
  output logic              sram_mode,
  output logic              sdram_mode,
  output logic              sdram_req,
  output logic              sdram_we,
  input  logic              sdram_ack,
  input  logic [DATA_W-1:0] sdram_rdata,
  output logic [DATA_W-1:0] sdram_wdata,
  output logic              sram_req,
  output logic              sram_we,
  input  logic              sram_ack,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              proc_start,
  input  logic              proc_done,
  output logic              busy,
  output logic              frame_done,
  output logic              dim_err
);

  xfer_state_t      state_q, state_d;
  logic [DIM_W-1:0] width_q, width_d;
  logic [DIM_W-1:0] width_m1_q, width_m1_d;
  logic [DIM_W-1:0] height_q, height_d;
  logic [DIM_W-1:0] word_cnt_q, word_cnt_d;
  logic [DIM_W-1:0] row_cnt_q, row_cnt_d;
  logic             sram_mode_q, sram_mode_d;
  logic             sdram_mode_q, sdram_mode_d;
  logic             busy_q, busy_d;
  logic             dim_err_q, dim_err_d;
  logic             frame_done_q, frame_done_d;
  logic             proc_start_q, proc_start_d;

  logic [DIM_W-1:0] word_inc, row_inc;
  logic             load_phase;
  logic             mv_go, mv_src_fire, mv_done;
  logic             mv_src_req, mv_dst_req, mv_src_ack, mv_dst_ack;
  logic [DATA_W-1:0] mv_src_rdata, mv_data;

  assign word_inc   = word_cnt_q + DIM_W'(1);
  assign row_inc    = row_cnt_q + DIM_W'(1);
  assign load_phase = (sram_mode_q == SRAM_ROWCACHE);

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    width_m1_d   = width_m1_q;
    height_d     = height_q;
    word_cnt_d   = word_cnt_q;
    row_cnt_d    = row_cnt_q;
    sram_mode_d  = sram_mode_q;
    sdram_mode_d = sdram_mode_q;
    busy_d       = busy_q;
    dim_err_d    = dim_err_q;
    frame_done_d = 1'b0;
    proc_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          width_d      = image_width;
          width_m1_d   = image_width - DIM_W'(1);
          height_d     = image_height;
          word_cnt_d   = '0;
          row_cnt_d    = '0;
          busy_d       = 1'b1;
          dim_err_d    = 1'b0;
          sram_mode_d  = SRAM_ROWCACHE;
          sdram_mode_d = SDRAM_READ;
          if (image_width < DIM_W'(2) || image_height == '0) begin
            dim_err_d = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = INIT;
          end
        end
      end
      INIT:   state_d = LD_RD;
      LD_RD:  if (mv_src_fire) state_d = LD_WR;
      LD_WR:  if (mv_done) state_d = LD_UPD;
      LD_UPD: begin
        word_cnt_d = word_inc;
        if (word_inc < width_q) begin
          state_d = LD_RD;
        end else begin
          state_d      = PROC;
          proc_start_d = 1'b1;
        end
      end
      PROC: begin
        if (proc_done) begin
          word_cnt_d = '0;
          state_d    = ST_RD;
        end
      end
      ST_RD:  if (mv_src_fire) state_d = ST_WR;
      ST_WR:  if (mv_done) state_d = ST_UPD;
      ST_UPD: begin
        word_cnt_d = word_inc;
        state_d    = (word_inc == width_m1_q) ? ROW_END : ST_RD;
      end
      ROW_END: begin
        row_cnt_d  = row_inc;
        word_cnt_d = '0;
        state_d    = (row_inc < height_q) ? LD_RD : DONE;
      end
      DONE: begin
        busy_d       = 1'b0;
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Modes switch only when a phase is entered, so they hold through its UPD cycles.
    if (state_d == LD_RD && state_q != LD_RD) begin
      sram_mode_d  = SRAM_ROWCACHE;
      sdram_mode_d = SDRAM_READ;
    end else if (state_d == ST_RD && state_q != ST_RD) begin
      sram_mode_d  = SRAM_OUTPUT;
      sdram_mode_d = SDRAM_WRITE;
    end
  end

  assign mv_go = (state_d == LD_RD && state_q != LD_RD) ||
                 (state_d == ST_RD && state_q != ST_RD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      width_q      <= '0;
      width_m1_q   <= '0;
      height_q     <= '0;
      word_cnt_q   <= '0;
      row_cnt_q    <= '0;
      sram_mode_q  <= SRAM_ROWCACHE;
      sdram_mode_q <= SDRAM_READ;
      busy_q       <= 1'b0;
      dim_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      proc_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      width_m1_q   <= width_m1_d;
      height_q     <= height_d;
      word_cnt_q   <= word_cnt_d;
      row_cnt_q    <= row_cnt_d;
      sram_mode_q  <= sram_mode_d;
      sdram_mode_q <= sdram_mode_d;
      busy_q       <= busy_d;
      dim_err_q    <= dim_err_d;
      frame_done_q <= frame_done_d;
      proc_start_q <= proc_start_d;
    end
  end

  // Load reads SDRAM and writes SRAM; store is the mirror image.
  assign mv_src_ack   = load_phase ? sdram_ack : sram_ack;
  assign mv_src_rdata = load_phase ? sdram_rdata : sram_rdata;
  assign mv_dst_ack   = load_phase ? sram_ack : sdram_ack;

  word_mover #(
    .W(DATA_W)
  ) u_mover (
    .clk        (clk),
    .rst        (rst),
    .go_i       (mv_go),
    .src_ack_i  (mv_src_ack),
    .src_rdata_i(mv_src_rdata),
    .dst_ack_i  (mv_dst_ack),
    .src_req_o  (mv_src_req),
    .dst_req_o  (mv_dst_req),
    .data_o     (mv_data),
    .src_fire_o (mv_src_fire),
    .done_o     (mv_done)
  );

  assign sdram_req   = load_phase ? mv_src_req : mv_dst_req;
  assign sdram_we    = !load_phase && mv_dst_req;
  assign sram_req    = load_phase ? mv_dst_req : mv_src_req;
  assign sram_we     = load_phase && mv_dst_req;
  assign sdram_wdata = mv_data;
  assign sram_wdata  = mv_data;

  assign calc_start = (state_q == INIT);
  assign update     = (state_q == LD_UPD) || (state_q == ST_UPD);
  assign sram_mode  = sram_mode_q;
  assign sdram_mode = sdram_mode_q;
  assign proc_start = proc_start_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dim_err    = dim_err_q;

endmodule

// File: tb/tb_row_transfer_ctrl.sv
// Bench for row_transfer_ctrl: SDRAM/SRAM/filter responders with a word
// scoreboard, a table of frames, and hand-written reset/ignored-input runs.
module tb_row_transfer_ctrl;
  import xfer_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  image_width = '0;
  logic [DIM_W-1:0]  image_height = '0;
  logic              calc_start, update, sram_mode, sdram_mode;
  logic              sdram_req, sdram_we, sram_req, sram_we;
  logic              sdram_ack, sram_ack, proc_start, proc_done;
  logic              busy, frame_done, dim_err;
  logic [DATA_W-1:0] sdram_rdata, sdram_wdata, sram_rdata, sram_wdata;

  always #5 clk = ~clk;

  row_transfer_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .image_width(image_width), .image_height(image_height),
    .calc_start(calc_start), .update(update),
    .sram_mode(sram_mode), .sdram_mode(sdram_mode),
    .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_ack(sdram_ack),
    .sdram_rdata(sdram_rdata), .sdram_wdata(sdram_wdata),
    .sram_req(sram_req), .sram_we(sram_we), .sram_ack(sram_ack),
    .sram_rdata(sram_rdata), .sram_wdata(sram_wdata),
    .proc_start(proc_start), .proc_done(proc_done),
    .busy(busy), .frame_done(frame_done), .dim_err(dim_err)
  );

  typedef struct {
    int w; int h; int sram_dly; int sdram_dly;
    int sdr_rd; int sr_wr; int sr_rd; int sdr_wr; int upd; int proc_n;
    bit err;
  } vec_t;

  typedef struct {
    int sdr_rd; int sdr_wr; int sr_rd; int sr_wr; int upd; int proc_n;
    int fd; int calc; int req; int mode; int hold; int sb;
  } cnt_t;

  // Responder-owned counters (written only by the responder process)
  int n_sdr_rd = 0, n_sdr_wr = 0, n_sr_rd = 0, n_sr_wr = 0;
  int n_upd = 0, n_proc = 0, n_fd = 0, n_calc = 0, n_req_cyc = 0;
  int mode_bad = 0, hold_bad = 0, sb_bad = 0;
  logic [DATA_W-1:0] sb_q[$];

  // Test-owned knobs and results
  int sram_dly = 0, sdram_dly = 0, stray_req = 0;
  int n_cmp = 0, n_bad = 0;
  cnt_t base;
  logic calc1, busy1, fd2, err2, req2;

  function automatic cnt_t get_cnt();
    cnt_t c;
    c.sdr_rd = n_sdr_rd; c.sdr_wr = n_sdr_wr; c.sr_rd = n_sr_rd; c.sr_wr = n_sr_wr;
    c.upd = n_upd; c.proc_n = n_proc; c.fd = n_fd; c.calc = n_calc; c.req = n_req_cyc;
    c.mode = mode_bad; c.hold = hold_bad; c.sb = sb_bad;
    return c;
  endfunction

  task automatic sb_pop(input string name, input logic [DATA_W-1:0] got);
    logic [DATA_W-1:0] exp_w;
    if (sb_q.size() == 0) begin
      sb_bad++;
      $display("FAIL %s: write of %h with no word pending", name, got);
    end else begin
      exp_w = sb_q.pop_front();
      if (got !== exp_w) begin
        sb_bad++;
        $display("FAIL %s: got %h expected %h", name, got, exp_w);
      end
    end
  endtask

  // Memory, filter and monitor model; acks are driven at negedge for the next posedge.
  initial begin : responder
    int sdram_wait, sram_wait, proc_cnt, stray_seen;
    bit phase_load, stray_now;
    logic [DATA_W-1:0] pat_a, pat_b, held;
    sdram_wait = 0; sram_wait = 0; proc_cnt = 0; stray_seen = 0;
    phase_load = 1'b1; pat_a = 16'hA000; pat_b = 16'h5000; held = '0;
    sdram_ack = 1'b0; sram_ack = 1'b0; proc_done = 1'b0;
    sdram_rdata = '0; sram_rdata = '0;
    forever begin
      @(negedge clk);
      stray_now = 1'b0;
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        stray_now  = 1'b1;
      end
      proc_done = stray_now;
      if (rst || !busy) sb_q.delete();
      if (update) begin
        n_upd++;
        if ({sram_mode, sdram_mode} !== (phase_load ? 2'b11 : 2'b00)) begin
          mode_bad++;
          $display("FAIL mode_at_update: got %b expected %b", {sram_mode, sdram_mode},
                   phase_load ? 2'b11 : 2'b00);
        end
      end
      if (proc_start) begin
        n_proc++;
        proc_cnt = 3;
      end else if (proc_cnt > 0) begin
        proc_cnt--;
        if (proc_cnt == 0) proc_done = 1'b1;
      end
      if (frame_done) n_fd++;
      if (calc_start) n_calc++;
      if (sdram_req || sram_req) n_req_cyc++;

      sdram_ack = 1'b0;
      if (sdram_req) begin
        if (sdram_wait >= sdram_dly) begin
          sdram_ack  = 1'b1;
          sdram_wait = 0;
          if (sdram_we) begin
            n_sdr_wr++;
            sb_pop("sdram_wdata", sdram_wdata);
          end else begin
            pat_a = pat_a + 16'h0111;
            sdram_rdata = pat_a;
            sb_q.push_back(pat_a);
            n_sdr_rd++;
            phase_load = 1'b1;
          end
        end else begin
          sdram_wait++;
        end
      end else begin
        sdram_wait = 0;
      end

      sram_ack = 1'b0;
      if (sram_req) begin
        if (sram_we) begin
          if (sram_wait == 0) held = sram_wdata;
          else if (sram_wdata !== held) begin
            hold_bad++;
            $display("FAIL sram_wdata_hold: got %h expected %h", sram_wdata, held);
          end
        end
        if (sram_wait >= sram_dly) begin
          sram_ack  = 1'b1;
          sram_wait = 0;
          if (sram_we) begin
            n_sr_wr++;
            sb_pop("sram_wdata", sram_wdata);
          end else begin
            pat_b = pat_b + 16'h0023;
            sram_rdata = pat_b;
            sb_q.push_back(pat_b);
            n_sr_rd++;
            phase_load = 1'b0;
          end
        end else begin
          sram_wait++;
        end
      end else begin
        sram_wait = 0;
        sram_ack  = stray_now;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic [11:0] ctrl_vec();
    return {sdram_req, sdram_we, sram_req, sram_we, calc_start, update,
            proc_start, busy, frame_done, dim_err, sram_mode, sdram_mode};
  endfunction

  task automatic start_frame(input int w, input int h);
    base = get_cnt();
    @(negedge clk);
    image_width  = DIM_W'(w);
    image_height = DIM_W'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    calc1 = calc_start;
    busy1 = busy;
    @(negedge clk);
    fd2  = frame_done;
    err2 = dim_err;
    req2 = sdram_req;
  endtask

  task automatic check_early(input vec_t v, input string tag);
    check({tag, "/calc_start@1"}, 64'(calc1), v.err ? 64'd0 : 64'd1);
    check({tag, "/busy@1"}, 64'(busy1), 64'd1);
    check({tag, "/frame_done@2"}, 64'(fd2), v.err ? 64'd1 : 64'd0);
    check({tag, "/dim_err@2"}, 64'(err2), v.err ? 64'd1 : 64'd0);
    check({tag, "/sdram_req@2"}, 64'(req2), v.err ? 64'd0 : 64'd1);
  endtask

  task automatic finish_frame(input vec_t v, input string tag);
    int cyc;
    cnt_t cur;
    cyc = 0;
    while (!frame_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/frame_done_seen"}, 64'(frame_done), 64'd1);
    @(negedge clk);
    cur = get_cnt();
    check({tag, "/busy_after"}, 64'(busy), 64'd0);
    check({tag, "/dim_err"}, 64'(dim_err), v.err ? 64'd1 : 64'd0);
    check({tag, "/sdram_reads"}, 64'(cur.sdr_rd - base.sdr_rd), 64'(v.sdr_rd));
    check({tag, "/sram_writes"}, 64'(cur.sr_wr - base.sr_wr), 64'(v.sr_wr));
    check({tag, "/sram_reads"}, 64'(cur.sr_rd - base.sr_rd), 64'(v.sr_rd));
    check({tag, "/sdram_writes"}, 64'(cur.sdr_wr - base.sdr_wr), 64'(v.sdr_wr));
    check({tag, "/updates"}, 64'(cur.upd - base.upd), 64'(v.upd));
    check({tag, "/proc_starts"}, 64'(cur.proc_n - base.proc_n), 64'(v.proc_n));
    check({tag, "/frame_dones"}, 64'(cur.fd - base.fd), 64'd1);
    check({tag, "/calc_starts"}, 64'(cur.calc - base.calc), v.err ? 64'd0 : 64'd1);
    check({tag, "/mode_errors"}, 64'(cur.mode - base.mode), 64'd0);
    check({tag, "/hold_errors"}, 64'(cur.hold - base.hold), 64'd0);
    check({tag, "/scoreboard_errors"}, 64'(cur.sb - base.sb), 64'd0);
    if (v.err) check({tag, "/req_cycles"}, 64'(cur.req - base.req), 64'd0);
    $display("frame %s w=%0d h=%0d: %0d loads, %0d stores, %0d updates, dim_err=%0b",
             tag, v.w, v.h, cur.sr_wr - base.sr_wr, cur.sdr_wr - base.sdr_wr,
             cur.upd - base.upd, dim_err);
  endtask

  initial begin : test
    vec_t vecs[6];
    vec_t v;
    int cyc;
    //          w  h sr sd  sdrd srwr srrd sdwr upd proc err
    vecs[0] = '{4, 2, 0, 0, 8,   8,   6,   6,   14, 2,   1'b0};
    vecs[1] = '{3, 1, 0, 1, 3,   3,   2,   2,   5,  1,   1'b0};
    vecs[2] = '{2, 3, 1, 0, 6,   6,   3,   3,   9,  3,   1'b0};
    vecs[3] = '{1, 5, 0, 0, 0,   0,   0,   0,   0,  0,   1'b1};
    vecs[4] = '{5, 0, 0, 0, 0,   0,   0,   0,   0,  0,   1'b1};
    vecs[5] = '{6, 1, 3, 0, 6,   6,   5,   5,   11, 1,   1'b0};

    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset/ctrl", 64'(ctrl_vec()), 64'(12'b0000_0000_0011));
    check("reset/wdata", 64'({sram_wdata, sdram_wdata}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sram_dly  = vecs[i].sram_dly;
      sdram_dly = vecs[i].sdram_dly;
      start_frame(vecs[i].w, vecs[i].h);
      check_early(vecs[i], $sformatf("vec%0d", i));
      finish_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while word 2 of the first row waits in LD_WR
    sram_dly  = 3;
    sdram_dly = 0;
    start_frame(4, 2);
    cyc = 0;
    while (!((n_sdr_rd - base.sdr_rd) == 2 && sram_req) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset/in_ld_wr", 64'(sram_req && sram_we), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset/ctrl", 64'(ctrl_vec()), 64'(12'b0000_0000_0011));
    check("midreset/wdata", 64'({sram_wdata, sdram_wdata}), 64'd0);
    rst = 1'b0;
    sram_dly = 0;
    start_frame(4, 2);
    check_early(vecs[0], "after_reset");
    finish_frame(vecs[0], "after_reset");

    // start, proc_done and sram_ack pulsed while LD_RD waits on SDRAM
    v = vecs[0];
    v.sdram_dly = 2;
    sdram_dly = 2;
    start_frame(v.w, v.h);
    check_early(v, "ignored");
    cyc = 0;
    while (!((n_sr_wr - base.sr_wr) >= 3 && sdram_req) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("ignored/in_ld_rd", 64'(sdram_req && !sdram_we), 64'd1);
    image_width  = DIM_W'(7);
    image_height = DIM_W'(9);
    start = 1'b1;
    stray_req++;
    @(negedge clk);
    start = 1'b0;
    finish_frame(v, "ignored");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
